packet_cutter: RTL and testbench
================================

Name: packet_cutter

Overview:
AXI4-Stream packet truncator with an AXI4-Lite register interface. It sits in the monitor datapath between capture and host DMA. Packets longer than a programmed byte length are truncated to a programmed number of words. The last kept word is strobe-masked and carries TLAST, and the TUSER length field is rewritten. All other packets pass through unchanged.

Parameters:
C_S_AXIS_DATA_WIDTH, 256, slave stream data width; TSTRB width is this value divided by 8.
C_M_AXIS_DATA_WIDTH, 256, master stream data width; must equal C_S_AXIS_DATA_WIDTH.
C_S_AXIS_TUSER_WIDTH, 128, slave TUSER width.
C_M_AXIS_TUSER_WIDTH, 128, master TUSER width; must equal C_S_AXIS_TUSER_WIDTH.
HASH_WIDTH, 128, reserved for a future digest field; must be at most the data width; no logic depends on it.
C_S_AXI_ADDR_WIDTH, 32, AXI-Lite address width.
C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width.

Ports:
S_AXI_ACLK  in  1  single clock for all logic.
S_AXI_ARESETN  in  1  reset; asynchronous, active-low.
S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  32/1/1  write address channel.
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  32/1/1  read address channel.
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.
S_AXIS_TDATA/TSTRB/TUSER/TVALID/TREADY/TLAST  in/in/in/in/out/in  256/32/128/1/1/1  input stream.
M_AXIS_TDATA/TSTRB/TUSER/TVALID/TREADY/TLAST  out/out/out/out/in/out  256/32/128/1/1/1  output stream.

Behaviour:
- Register decode uses address bits [3:2] only; upper bits are ignored.
  - 0x0 CUT_EN: bit0 enables cutting; reset 0.
  - 0x4 CUT_WORDS: number of full words kept; reset 0.
  - 0x8 CUT_STRB: TSTRB mask for the final kept word; reset 0xFFFFFFFF.
  - 0xC CUT_BYTES: new length in bytes, bits [15:0] used; reset 0.
- WSTRB is honoured per byte lane.
- AXI-Lite write:
  - Accepted in the cycle where AWVALID and WVALID are both high and no response is pending.
  - AWREADY and WREADY pulse high for exactly that cycle.
  - The register updates on that edge.
  - BVALID is asserted the next cycle and held until BREADY; BRESP=00.
  - A one-cycle valid pulse must be accepted.
- AXI-Lite read:
  - ARREADY pulses when ARVALID is high and RVALID is low.
  - RVALID and RDATA appear the next cycle and are held until RREADY; RRESP=00.
- Reset values: all AXI-Lite ready/valid outputs are 0; the datapath FSM is in IDLE.
- Datapath FSM has zero latency: output is combinational from input and state.
  - IDLE, first word: configuration is latched into shadow copies when S_TVALID&&S_TREADY on the first word. Later register writes do not affect a packet in flight.
  - The packet is cut when CUT_EN=1, CUT_BYTES[15:0] is less than S_AXIS_TUSER[15:0], and TLAST is not set on the first word.
  - When cut, M_TUSER = {S_TUSER[127:16], CUT_BYTES[15:0]} on every word. Otherwise TUSER passes unchanged.
  - PASS state: M = S, S_TREADY = M_TREADY.
  - Word counter (16-bit, saturating) counts accepted words starting at 0.
  - In a cut packet, the word with index equal to CUT_WORDS is output with M_TSTRB = S_TSTRB & CUT_STRB and M_TLAST=1.
  - After that word the FSM enters DROP.
  - If the input TLAST arrives at or before index CUT_WORDS, the packet passes unchanged and the FSM returns to IDLE.
- DROP state:
  - S_TREADY=1 and M_TVALID=0.
  - Input words are discarded until an accepted TLAST, then the FSM returns to IDLE.
- CUT_WORDS=0 with cut active: only the first word is emitted, masked, with TLAST.
- Reset mid-packet: the FSM returns to IDLE. The rest of the in-flight packet is treated as a new packet (upstream is responsible for a clean restart).

Test Plan:
- Register program: write 0x4=2, 0x8=0xFFFFFFF0, 0xC=0x292, 0x0=1 as single-cycle AW/W pulses -> each gets one BVALID; readback returns the written values.
- Cut packet: TUSER 0x0201AAAA, 34 words (2 header + 32 payload), TSTRB all ones, M_TREADY=1 -> 3 output words.
  - Word 2 has TSTRB=0xFFFFFFF0 and TLAST=1.
  - All output words have TUSER[31:0]=0x02010292.
  - The remaining 31 input words are accepted with M_TVALID=0.
- Disabled: same packet with CUT_EN=0 -> 34 words, identical to the input, TLAST on word 33.
- Short packet: TUSER length 0x0040 with CUT_BYTES=0x292 -> passes unchanged.
- Backpressure: toggle M_TREADY during the cut packet -> no word is lost or duplicated, and TLAST still appears on kept word 2.
- Mid-packet register write: change CUT_WORDS to 5 during packet A -> A is cut at 3 words; the next packet is cut at 6 words.

Source files
------------

// File: rtl/packet_cutter.sv
// rtl/packet_cutter.sv - AXI4-Stream packet truncator with AXI4-Lite configuration registers
module packet_cutter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int HASH_WIDTH           = 128,
    parameter int C_S_AXI_ADDR_WIDTH   = 32,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                                S_AXI_ACLK,
    input  logic                                S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    input  logic                                S_AXIS_TLAST,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    input  logic                                M_AXIS_TREADY,
    output logic                                M_AXIS_TLAST
);
    localparam int RW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UNUSED_HASH_W = HASH_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_CUT  = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [RW-1:0] regs_q [4];
    logic          bvalid_q;
    logic          rvalid_q;
    logic [RW-1:0] rdata_q;
    logic          wr_en;
    logic          rd_en;
    logic [1:0]    waddr;
    logic [1:0]    raddr;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4], S_AXI_AWADDR[1:0],
                                S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4], S_AXI_ARADDR[1:0]};

    assign waddr = S_AXI_AWADDR[3:2];
    assign raddr = S_AXI_ARADDR[3:2];
    assign wr_en = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
    assign rd_en = S_AXI_ARVALID && !rvalid_q;

    assign S_AXI_AWREADY = wr_en;
    assign S_AXI_WREADY  = wr_en;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = rd_en;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            regs_q[0] <= '0;
            regs_q[1] <= '0;
            regs_q[2] <= '1;
            regs_q[3] <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (wr_en) begin
                for (int i = 0; i < RW / 8; i++) begin
                    if (S_AXI_WSTRB[i]) regs_q[waddr][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
                end
                bvalid_q <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= regs_q[raddr];
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    logic [1:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [RW-1:0] sh_words_q, sh_words_d;
    logic [RW-1:0] sh_strb_q, sh_strb_d;
    logic [15:0]   sh_bytes_q, sh_bytes_d;

    logic          s_hs;
    logic          cut_now;
    logic          cutting;
    logic          last_kept;
    logic [RW-1:0] eff_words;
    logic [RW-1:0] eff_strb;
    logic [15:0]   eff_bytes;
    logic [15:0]   idx;

    // First word decides using the live registers; later words use the shadow copies.
    assign cut_now   = regs_q[0][0] && (regs_q[3][15:0] < S_AXIS_TUSER[15:0]) && !S_AXIS_TLAST;
    assign cutting   = (state_q == ST_IDLE) ? cut_now : (state_q == ST_CUT);
    assign eff_words = (state_q == ST_IDLE) ? regs_q[1] : sh_words_q;
    assign eff_strb  = (state_q == ST_IDLE) ? regs_q[2] : sh_strb_q;
    assign eff_bytes = (state_q == ST_IDLE) ? regs_q[3][15:0] : sh_bytes_q;
    assign idx       = (state_q == ST_IDLE) ? 16'd0 : cnt_q;
    assign last_kept = cutting && (RW'(idx) == eff_words) && !S_AXIS_TLAST;

    assign S_AXIS_TREADY = (state_q == ST_DROP) ? 1'b1 : M_AXIS_TREADY;
    assign s_hs          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign M_AXIS_TVALID = (state_q == ST_DROP) ? 1'b0 : S_AXIS_TVALID;
    assign M_AXIS_TDATA  = S_AXIS_TDATA;
    assign M_AXIS_TSTRB  = last_kept ? (S_AXIS_TSTRB & eff_strb[SW-1:0]) : S_AXIS_TSTRB;
    assign M_AXIS_TLAST  = S_AXIS_TLAST || last_kept;
    assign M_AXIS_TUSER  = cutting ? {S_AXIS_TUSER[C_S_AXIS_TUSER_WIDTH-1:16], eff_bytes}
                                   : S_AXIS_TUSER;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_words_d = sh_words_q;
        sh_strb_d  = sh_strb_q;
        sh_bytes_d = sh_bytes_q;
        if (s_hs) begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            case (state_q)
                ST_IDLE: begin
                    cnt_d      = 16'd1;
                    sh_words_d = regs_q[1];
                    sh_strb_d  = regs_q[2];
                    sh_bytes_d = regs_q[3][15:0];
                    if (S_AXIS_TLAST)   state_d = ST_IDLE;
                    else if (last_kept) state_d = ST_DROP;
                    else if (cut_now)   state_d = ST_CUT;
                    else                state_d = ST_PASS;
                end
                ST_PASS: if (S_AXIS_TLAST) state_d = ST_IDLE;
                ST_CUT: begin
                    if (S_AXIS_TLAST)   state_d = ST_IDLE;
                    else if (last_kept) state_d = ST_DROP;
                end
                default: if (S_AXIS_TLAST) state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sh_words_q <= '0;
            sh_strb_q  <= '1;
            sh_bytes_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_words_q <= sh_words_d;
            sh_strb_q  <= sh_strb_d;
            sh_bytes_q <= sh_bytes_d;
        end
    end
endmodule

// File: tb/tb_packet_cutter.sv
// tb/tb_packet_cutter.sv - randomized and directed bench for packet_cutter against a packet-level model
module tb_packet_cutter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  AWADDR = '0, WDATA = '0, ARADDR = '0, RDATA;
    logic [3:0]   WSTRB = '0;
    logic         AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
    logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]   BRESP, RRESP;
    logic [255:0] S_TDATA = '0, M_TDATA;
    logic [31:0]  S_TSTRB = '0, M_TSTRB;
    logic [127:0] S_TUSER = '0, M_TUSER;
    logic         S_TVALID = 0, S_TLAST = 0, S_TREADY;
    logic         M_TVALID, M_TLAST;
    logic         M_TREADY = 1'b1;

    always #5 clk = ~clk;

    packet_cutter dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .S_AXIS_TDATA(S_TDATA), .S_AXIS_TSTRB(S_TSTRB), .S_AXIS_TUSER(S_TUSER),
        .S_AXIS_TVALID(S_TVALID), .S_AXIS_TREADY(S_TREADY), .S_AXIS_TLAST(S_TLAST),
        .M_AXIS_TDATA(M_TDATA), .M_AXIS_TSTRB(M_TSTRB), .M_AXIS_TUSER(M_TUSER),
        .M_AXIS_TVALID(M_TVALID), .M_AXIS_TREADY(M_TREADY), .M_AXIS_TLAST(M_TLAST)
    );

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    beat_t       out_q[$];
    beat_t       exp_q[$];
    logic [31:0] tb_regs[4];
    int          checks = 0;
    int          errors = 0;
    bit          bp = 0;
    int          pkt_no = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        M_TREADY = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (M_TVALID && M_TREADY) begin
            beat_t b;
            b.d = M_TDATA; b.s = M_TSTRB; b.u = M_TUSER; b.l = M_TLAST;
            out_q.push_back(b);
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic acc;
        int   nb = 0;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
        @(negedge clk); acc = AWREADY && WREADY;
        @(posedge clk); #1;
        AWVALID = 0; WVALID = 0;
        check($sformatf("aw_accept_%0h", a), acc, 1'b1);
        BREADY = 1;
        repeat (3) begin
            @(negedge clk);
            if (BVALID) begin
                nb++;
                check("bresp", BRESP, 2'b00);
            end
            @(posedge clk); #1;
        end
        BREADY = 0;
        check($sformatf("bvalid_count_%0h", a), nb, 1);
        for (int i = 0; i < 4; i++)
            if (s[i]) tb_regs[a[3:2]][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        logic acc;
        bit   got = 0;
        d = 'x;
        ARADDR = a; ARVALID = 1;
        @(negedge clk); acc = ARREADY;
        @(posedge clk); #1;
        ARVALID = 0; RREADY = 1;
        for (int t = 0; t < 8 && !got; t++) begin
            @(negedge clk);
            if (RVALID) begin
                got = 1; d = RDATA;
                check("rresp", RRESP, 2'b00);
            end
            @(posedge clk); #1;
        end
        RREADY = 0;
        check($sformatf("ar_accept_%0h", a), acc, 1'b1);
        check($sformatf("rvalid_seen_%0h", a), got, 1'b1);
    endtask

    task automatic read_check(input logic [31:0] a, input logic [31:0] expv);
        logic [31:0] d;
        axi_read(a, d);
        check($sformatf("readback_%0h", a), d, expv);
    endtask

    task automatic drive(input logic [255:0] dq[$], input logic [31:0] sq[$],
                         input logic [127:0] tuser, input bit gaps);
        for (int i = 0; i < dq.size(); i++) begin
            bit hs = 0;
            int t = 0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                S_TVALID = 0;
                @(posedge clk); #1;
            end
            S_TVALID = 1; S_TDATA = dq[i]; S_TSTRB = sq[i]; S_TUSER = tuser;
            S_TLAST = (i == dq.size() - 1);
            while (!hs && t < 200) begin
                @(negedge clk); hs = S_TREADY;
                @(posedge clk); #1;
                t++;
            end
            if (!hs) begin
                check("input_handshake_timeout", 0, 1);
                break;
            end
        end
        S_TVALID = 0; S_TLAST = 0;
    endtask

    // Model works on whole packets: decide cut, compute kept count, mask the final kept word.
    task automatic run_packet(input int len, input logic [127:0] tuser, input bit rnd_strb,
                              input bit bp_en, input int mid_words);
        logic [31:0]  cfg[4];
        logic [255:0] dq[$];
        logic [31:0]  sq[$];
        bit           cut, trunc;
        longint       keep;
        cfg = tb_regs;
        for (int i = 0; i < len; i++) begin
            dq.push_back({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            sq.push_back(rnd_strb ? $urandom : 32'hFFFF_FFFF);
        end
        cut   = cfg[0][0] && (cfg[3][15:0] < tuser[15:0]) && (len > 1);
        keep  = cut ? ((len < longint'(cfg[1]) + 1) ? len : longint'(cfg[1]) + 1) : len;
        trunc = cut && (len > longint'(cfg[1]) + 1);
        exp_q.delete();
        for (int i = 0; i < keep; i++) begin
            beat_t b;
            b.d = dq[i];
            b.s = (trunc && i == keep - 1) ? (sq[i] & cfg[2]) : sq[i];
            b.u = cut ? {tuser[127:16], cfg[3][15:0]} : tuser;
            b.l = (i == keep - 1);
            exp_q.push_back(b);
        end
        out_q.delete();
        bp = bp_en;
        fork
            drive(dq, sq, tuser, bp_en);
            if (mid_words >= 0) begin
                repeat (4) @(posedge clk);
                #1;
                axi_write(32'h4, mid_words, 4'hF);
            end
        join
        bp = 0;
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("pkt%0d_out_count", pkt_no), out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            check($sformatf("pkt%0d_w%0d_data", pkt_no, i), out_q[i].d, exp_q[i].d);
            check($sformatf("pkt%0d_w%0d_strb", pkt_no, i), out_q[i].s, exp_q[i].s);
            check($sformatf("pkt%0d_w%0d_user", pkt_no, i), out_q[i].u, exp_q[i].u);
            check($sformatf("pkt%0d_w%0d_last", pkt_no, i), out_q[i].l, exp_q[i].l);
        end
        pkt_no++;
    endtask

    initial begin
        tb_regs[0] = 32'h0; tb_regs[1] = 32'h0; tb_regs[2] = 32'hFFFF_FFFF; tb_regs[3] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", AWREADY, 1'b0);
        check("rst_bvalid", BVALID, 1'b0);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_arready", ARREADY, 1'b0);
        check("rst_m_tvalid", M_TVALID, 1'b0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        read_check(32'h0, 32'h0);
        read_check(32'h8, 32'hFFFF_FFFF);
        read_check(32'hC, 32'h0);

        axi_write(32'h4, 32'd2, 4'hF);
        axi_write(32'h8, 32'hFFFF_FFF0, 4'hF);
        axi_write(32'hC, 32'h292, 4'hF);
        axi_write(32'h0, 32'h1, 4'hF);
        read_check(32'h4, 32'd2);
        read_check(32'h8, 32'hFFFF_FFF0);
        read_check(32'hC, 32'h292);
        read_check(32'h0, 32'h1);
        read_check(32'h1008, 32'hFFFF_FFF0);

        // Cut packet: 34 words in, 3 out.
        run_packet(34, 128'h0201AAAA, 0, 0, -1);
        check("cut_count", out_q.size(), 3);
        if (out_q.size() == 3) begin
            check("cut_w2_strb", out_q[2].s, 32'hFFFF_FFF0);
            check("cut_w2_last", out_q[2].l, 1'b1);
            for (int i = 0; i < 3; i++)
                check($sformatf("cut_w%0d_tuser", i), out_q[i].u[31:0], 32'h0201_0292);
        end

        axi_write(32'h0, 32'h0, 4'hF);
        run_packet(34, 128'h0201AAAA, 0, 0, -1);
        check("disabled_count", out_q.size(), 34);
        if (out_q.size() == 34) check("disabled_last33", out_q[33].l, 1'b1);

        axi_write(32'h0, 32'h1, 4'hF);
        run_packet(34, 128'h02010040, 0, 0, -1);
        check("short_count", out_q.size(), 34);

        run_packet(34, 128'h0201AAAA, 0, 1, -1);
        check("bp_count", out_q.size(), 3);
        if (out_q.size() == 3) check("bp_w2_last", out_q[2].l, 1'b1);

        run_packet(34, 128'h0201AAAA, 0, 0, 5);
        check("mid_a_count", out_q.size(), 3);
        run_packet(34, 128'h0201AAAA, 0, 0, -1);
        check("mid_b_count", out_q.size(), 6);

        axi_write(32'hC, 32'hFFFF_FF55, 4'h1);
        read_check(32'hC, 32'h255);
        axi_write(32'h4, 32'h0, 4'hF);
        run_packet(5, 128'h0201AAAA, 0, 0, -1);
        check("words0_count", out_q.size(), 1);

        for (int n = 0; n < 16; n++) begin
            axi_write(32'h0, $urandom_range(0, 3), 4'hF);
            axi_write(32'h4, $urandom_range(0, 6), 4'hF);
            axi_write(32'h8, $urandom, 4'hF);
            axi_write(32'hC, $urandom_range(0, 96), 4'hF);
            run_packet($urandom_range(1, 10), {$urandom, $urandom, $urandom, 16'h0, 16'($urandom_range(0, 96))},
                       1, $urandom_range(0, 1) == 1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
